// File: rtl/lifo_pkg.sv
// Shared constants, helpers and types for the LIFO stack (lifo_stack, lifo_ram).
package lifo_pkg;

  localparam int LIFO_DWIDTH_DEF = 8;
  localparam int LIFO_AWIDTH_DEF = 4;

  // Count needs one bit more than the address so that "full" (DEPTH) is representable.
  typedef logic [LIFO_AWIDTH_DEF:0] lifo_cnt_t;

  typedef enum logic [1:0] {
    OP_IDLE = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_SWAP = 2'd3
  } lifo_op_e;

  function automatic int lifo_depth(input int awidth);
    return 1 << awidth;
  endfunction

endpackage

// File: rtl/lifo_ram.sv
// DEPTH x DWIDTH storage: one synchronous write port, one registered read port.
// Read-before-write on a shared address returns the old word (needed for push+pop).
module lifo_ram
  import lifo_pkg::*;
#(
  parameter int DWIDTH = LIFO_DWIDTH_DEF,
  parameter int AWIDTH = LIFO_AWIDTH_DEF
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              wr_en_i,
  input  logic [AWIDTH-1:0] wr_addr_i,
  input  logic [DWIDTH-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [AWIDTH-1:0] rd_addr_i,
  output logic [DWIDTH-1:0] rd_data_o
);

  localparam int DEPTH = lifo_depth(AWIDTH);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [DWIDTH-1:0] rd_data_q;

  // Contents are deliberately never cleared so the array maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/lifo_stack.sv
// Synchronous LIFO stack of 2**AWIDTH words with registered pop data and occupancy flags.
// Define LIFO_ASSERTIONS_EN to compile in simulation-only overflow/underflow assertions.
module lifo_stack
  import lifo_pkg::*;
#(
  parameter int DWIDTH = LIFO_DWIDTH_DEF,
  parameter int AWIDTH = LIFO_AWIDTH_DEF
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              wrreq_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              rdreq_i,
  output logic [DWIDTH-1:0] q_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [AWIDTH:0]   usedw_o
);

  localparam int DEPTH = lifo_depth(AWIDTH);
  localparam logic [AWIDTH:0] FULL_CNT = (AWIDTH + 1)'(DEPTH);

  logic [AWIDTH:0]   cnt_q;
  logic [AWIDTH:0]   cnt_d;
  lifo_op_e          op;
  logic              wr_en;
  logic              rd_en;
  logic [AWIDTH-1:0] wr_addr;
  logic [AWIDTH-1:0] top_addr;
  logic              is_empty;
  logic              is_full;

  assign is_empty = (cnt_q == '0);
  assign is_full  = (cnt_q == FULL_CNT);
  assign top_addr = cnt_q[AWIDTH-1:0] - AWIDTH'(1);

  always_comb begin
    op      = OP_IDLE;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_addr = cnt_q[AWIDTH-1:0];
    // A pop on an empty stack drops out here, so push+pop when empty degrades to a push.
    if (rdreq_i && !is_empty) begin
      op = wrreq_i ? OP_SWAP : OP_POP;
    end else if (wrreq_i && !is_full) begin
      op = OP_PUSH;
    end
    unique case (op)
      OP_PUSH: begin
        wr_en = 1'b1;
        cnt_d = cnt_q + (AWIDTH + 1)'(1);
      end
      OP_POP: begin
        rd_en = 1'b1;
        cnt_d = cnt_q - (AWIDTH + 1)'(1);
      end
      OP_SWAP: begin
        rd_en   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = top_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  lifo_ram #(
    .DWIDTH(DWIDTH),
    .AWIDTH(AWIDTH)
  ) u_ram (
    .clk_i    (clk_i),
    .srst_i   (srst_i),
    .wr_en_i  (wr_en),
    .wr_addr_i(wr_addr),
    .wr_data_i(data_i),
    .rd_en_i  (rd_en),
    .rd_addr_i(top_addr),
    .rd_data_o(q_o)
  );

  assign usedw_o = cnt_q;
  assign empty_o = is_empty;
  assign full_o  = is_full;

`ifdef LIFO_ASSERTIONS_EN
  a_overflow: assert property (@(posedge clk_i) disable iff (srst_i)
    !(wrreq_i && !rdreq_i && full_o))
    else $error("lifo_stack: push while full");

  a_underflow: assert property (@(posedge clk_i) disable iff (srst_i)
    !(rdreq_i && empty_o))
    else $error("lifo_stack: pop while empty");
`else
`endif

endmodule

// File: tb/tb_lifo_stack.sv
// Directed and model-checked bench for lifo_stack (DWIDTH=8, AWIDTH=4).
module tb_lifo_stack;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          srst;
  logic          wrreq;
  logic          rdreq;
  logic [DW-1:0] data;
  logic [DW-1:0] q;
  logic          empty;
  logic          full;
  logic [AW:0]   usedw;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lifo_stack #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk_i  (clk),
    .srst_i (srst),
    .wrreq_i(wrreq),
    .data_i (data),
    .rdreq_i(rdreq),
    .q_o    (q),
    .empty_o(empty),
    .full_o (full),
    .usedw_o(usedw)
  );

  // One clock edge with the given request; outputs are stable 1ns after the edge.
  task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
    wrreq = w;
    rdreq = r;
    data  = d;
    @(posedge clk);
    #1;
    wrreq = 1'b0;
    rdreq = 1'b0;
    $display("t=%0t srst=%0b wr=%0b rd=%0b din=%02h -> q=%02h usedw=%0d empty=%0b full=%0b",
             $time, srst, w, r, d, q, usedw, empty, full);
  endtask

  task automatic test_reset();
    srst = 1'b1;
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    srst = 1'b0;
    step(1'b0, 1'b0, 8'h00);
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q: got %02h expected 00", q); end
    checks++; if (usedw !== 5'd0) begin errors++; $display("FAIL reset_usedw: got %0d expected 0", usedw); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0b expected 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b expected 0", full); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 8'(i));
      checks++; if (usedw !== 5'(i + 1)) begin errors++; $display("FAIL fill_usedw[%0d]: got %0d expected %0d", i, usedw, i + 1); end
      checks++; if (full !== (i == 15)) begin errors++; $display("FAIL fill_full[%0d]: got %0b expected %0b", i, full, (i == 15)); end
    end
    // 17th push is dropped.
    step(1'b1, 1'b0, 8'hFF);
    checks++; if (usedw !== 5'd16) begin errors++; $display("FAIL overflow_usedw: got %0d expected 16", usedw); end
    checks++; if (full !== 1'b1 || empty !== 1'b0) begin errors++; $display("FAIL overflow_flags: got full=%0b empty=%0b expected 1/0", full, empty); end
    // Push+pop while full replaces the top and returns the old top.
    step(1'b1, 1'b1, 8'hEE);
    checks++; if (q !== 8'h0F) begin errors++; $display("FAIL swap_full_q: got %02h expected 0f", q); end
    checks++; if (usedw !== 5'd16) begin errors++; $display("FAIL swap_full_usedw: got %0d expected 16", usedw); end
  endtask

  task automatic test_drain();
    logic [DW-1:0] exp_q;
    for (int i = 0; i < 16; i++) begin
      exp_q = (i == 0) ? 8'hEE : 8'(15 - i);
      step(1'b0, 1'b1, 8'h00);
      checks++; if (q !== exp_q) begin errors++; $display("FAIL drain_q[%0d]: got %02h expected %02h", i, q, exp_q); end
      checks++; if (usedw !== 5'(15 - i)) begin errors++; $display("FAIL drain_usedw[%0d]: got %0d expected %0d", i, usedw, 15 - i); end
    end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL drain_flags: got empty=%0b full=%0b expected 1/0", empty, full); end
    step(1'b0, 1'b1, 8'h00);
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL underflow_q: got %02h expected 00", q); end
    checks++; if (usedw !== 5'd0) begin errors++; $display("FAIL underflow_usedw: got %0d expected 0", usedw); end
  endtask

  task automatic test_swap();
    step(1'b1, 1'b0, 8'hA1);
    step(1'b1, 1'b0, 8'hB2);
    step(1'b1, 1'b1, 8'hC3);
    checks++; if (q !== 8'hB2) begin errors++; $display("FAIL swap_q: got %02h expected b2", q); end
    checks++; if (usedw !== 5'd2) begin errors++; $display("FAIL swap_usedw: got %0d expected 2", usedw); end
    step(1'b0, 1'b1, 8'h00);
    checks++; if (q !== 8'hC3) begin errors++; $display("FAIL swap_pop1: got %02h expected c3", q); end
    step(1'b0, 1'b1, 8'h00);
    checks++; if (q !== 8'hA1) begin errors++; $display("FAIL swap_pop2: got %02h expected a1", q); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL swap_empty: got %0b expected 1", empty); end
    // Push+pop on empty: pop ignored, q holds, push lands.
    step(1'b1, 1'b1, 8'h77);
    checks++; if (q !== 8'hA1) begin errors++; $display("FAIL empty_swap_q: got %02h expected a1", q); end
    checks++; if (usedw !== 5'd1) begin errors++; $display("FAIL empty_swap_usedw: got %0d expected 1", usedw); end
    step(1'b0, 1'b1, 8'h00);
    checks++; if (q !== 8'h77) begin errors++; $display("FAIL empty_swap_pop: got %02h expected 77", q); end
  endtask

  task automatic test_random();
    logic [DW-1:0] stk[$];
    logic [DW-1:0] mq;
    logic [DW-1:0] d;
    logic [AW:0]   ecnt;
    logic          w;
    logic          r;
    srst = 1'b1;
    step(1'b0, 1'b0, 8'h00);
    srst = 1'b0;
    mq = 8'h00;
    for (int i = 0; i < 30; i++) begin
      w = ($urandom_range(0, 99) < 70);
      if (stk.size() == 16) w = 1'b0;
      if (stk.size() == 0) w = 1'b1;
      r = !w;
      d = 8'($urandom);
      step(w, r, d);
      if (w) stk.push_back(d);
      else mq = stk.pop_back();
      ecnt = 5'(stk.size());
      checks++;
      if ({q, usedw, empty, full} !== {mq, ecnt, (ecnt == 5'd0), (ecnt == 5'd16)}) begin
        errors++;
        $display("FAIL random[%0d]: got q=%02h usedw=%0d e=%0b f=%0b expected q=%02h usedw=%0d e=%0b f=%0b",
                 i, q, usedw, empty, full, mq, ecnt, (ecnt == 5'd0), (ecnt == 5'd16));
      end
    end
  endtask

  task automatic test_reset_mid();
    srst = 1'b1;
    step(1'b0, 1'b0, 8'h00);
    srst = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h30 + i));
    step(1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b0, 8'h35);
    checks++; if (usedw !== 5'd5) begin errors++; $display("FAIL mid_pre_usedw: got %0d expected 5", usedw); end
    checks++; if (q !== 8'h34) begin errors++; $display("FAIL mid_pre_q: got %02h expected 34", q); end
    // Reset wins over a simultaneous push.
    srst = 1'b1;
    step(1'b1, 1'b1, 8'h99);
    srst = 1'b0;
    checks++; if (usedw !== 5'd0) begin errors++; $display("FAIL mid_rst_usedw: got %0d expected 0", usedw); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mid_rst_empty: got %0b expected 1", empty); end
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL mid_rst_q: got %02h expected 00", q); end
    step(1'b1, 1'b0, 8'h5A);
    step(1'b0, 1'b1, 8'h00);
    checks++; if (q !== 8'h5A) begin errors++; $display("FAIL mid_after_q: got %02h expected 5a", q); end
    checks++; if (usedw !== 5'd0) begin errors++; $display("FAIL mid_after_usedw: got %0d expected 0", usedw); end
  endtask

  initial begin
    srst  = 1'b1;
    wrreq = 1'b0;
    rdreq = 1'b0;
    data  = '0;
    test_reset();
    test_fill();
    test_drain();
    test_swap();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lifo_stack.md
# lifo_stack

Synchronous last-in-first-out buffer of 2**AWIDTH words of DWIDTH bits. It serves as a small stack between a producer and a consumer sharing one clock. Read data is registered with one-cycle latency. Occupancy is reported through a count and full/empty flags.

## Interface
- DWIDTH, 8, data word width in bits
- AWIDTH, 4, address width; depth DEPTH = 2**AWIDTH
- clk_i  input  1  single clock, all logic on rising edge
- srst_i  input  1  reset, synchronous, active-high
- wrreq_i  input  1  push request, sampled each rising edge
- data_i  input  DWIDTH  push data, sampled with wrreq_i
- rdreq_i  input  1  pop request, sampled each rising edge
- q_o  output  DWIDTH  registered pop data
- empty_o  output  1  high when usedw_o == 0
- full_o  output  1  high when usedw_o == DEPTH
- usedw_o  output  AWIDTH+1  number of stored words, 0..DEPTH

## Operation
- Internal state: storage array of DEPTH words, and a stack pointer `cnt` (AWIDTH+1 bits) that equals the occupancy. The top of stack is at index cnt-1.
- Push only (wrreq_i=1, rdreq_i=0, not full): mem[cnt] <= data_i; cnt <= cnt+1.
- Pop only (rdreq_i=1, wrreq_i=0, not empty): q_o <= mem[cnt-1]; cnt <= cnt-1.
- Push and pop together, not empty:
  - q_o <= mem[cnt-1] (the old top).
  - mem[cnt-1] <= data_i.
  - cnt unchanged.
  - This case is also permitted when full.
- Push and pop together, empty: the pop is ignored and q_o holds; the push proceeds (cnt <= 1).
- Push when full without pop: ignored; memory and cnt unchanged.
- Pop when empty without push: ignored; q_o holds.
- No pop: q_o holds its last value.
- usedw_o = cnt; empty_o = (cnt==0); full_o = (cnt==DEPTH). All three derive from registered state, with no combinational path from the inputs.

## Timing
- Reset (srst_i high at a rising edge):
  - cnt <= 0 and q_o <= 0.
  - Hence usedw_o=0, empty_o=1, full_o=0.
  - Memory contents are not cleared.
- Reset has priority over wrreq_i/rdreq_i in the same cycle. Reset mid-operation discards all contents.
- Read latency is 1 cycle: q_o reflects the pop sampled at edge N immediately after edge N.
- usedw_o, empty_o and full_o reflect requests sampled at edge N immediately after edge N.
- Back-to-back pushes and pops are allowed every cycle; there is no handshake or backpressure beyond the flags.

## Configuration
- LIFO_ASSERTIONS_EN defined: simulation-only assertions are compiled in. They flag the following at the clock edge:
  - overflow: wrreq_i && !rdreq_i && full_o
  - underflow: rdreq_i && empty_o
- Without the macro: no assertions. RTL behaviour is identical either way, and illegal requests are ignored as above.

## Structure
- Shared package lifo_pkg: function/constant for DEPTH from AWIDTH; a typedef for the count width (AWIDTH+1).
- One natural sub-module, lifo_ram: DEPTH x DWIDTH memory with one synchronous write port and one synchronous registered read port. Its registered read output drives q_o.
- Pointer/flag logic lives in lifo_stack.

## Test plan
- Reset then idle: usedw_o=0, empty_o=1, full_o=0, q_o=0.
- Push 16 words 0x00..0x0F (AWIDTH=4): full_o=1 and usedw_o=16 after the 16th edge. A 17th push is ignored, and usedw_o stays 16.
- From full, 16 consecutive pops: q_o = 0x0F, 0x0E, ..., 0x00, one per cycle with 1-cycle latency. Then empty_o=1 and usedw_o=0. A further pop leaves q_o=0x00.
- Push 0xA1, 0xB2, then simultaneous push 0xC3 + pop: q_o=0xB2 and usedw_o stays 2. A following pop returns 0xC3, then 0xA1.
- Random 70/30 push/pop mix for 30 cycles, kept within bounds: q_o, usedw_o and the flags match a queue reference model each cycle.
- Reset asserted while usedw_o=5: next cycle usedw_o=0, empty_o=1, q_o=0. Subsequent push/pop of 0x5A returns 0x5A.
